// File: rtl/ddr3_init_pkg.sv
// Shared types and constants for the DDR3 power-up sequencer: FSM states,
// {cs_n,ras_n,cas_n,we_n} command encodings and the mode-register issue order.
package ddr3_init_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RST_HOLD,
        CKE_WAIT,
        XPR_WAIT,
        MRS_ISSUE,
        MRS_GAP,
        ZQ_ISSUE,
        ZQ_WAIT,
        DONE,
        USR_ISSUE,
        USR_GAP
    } state_t;

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_ZQCL  = 4'b0110;

    // Element [0] is issued first: MR2, MR3, MR1, MR0.
    localparam logic [3:0][1:0] MR_ORDER = {2'd0, 2'd1, 2'd3, 2'd2};

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A gap state follows a one-cycle issue state, so it lasts N-1 cycles
    // (counter load N-2) to keep command-to-command spacing at N.
    function automatic int gap_load(input int n);
        return (n >= 2) ? n - 2 : 0;
    endfunction

endpackage

// File: rtl/init_delay_timer.sv
// Down-counter shared by all wait states; expired is high while the count is zero.
module init_delay_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer: RESET#/CKE hold, tXPR, MR2/MR3/MR1/MR0, ZQCL, then
// hands the bus to the translator and serves runtime MRS requests.
module ddr3_init_sequencer
    import ddr3_init_pkg::*;
#(
    parameter int          T_RESET_CYC  = 8,
    parameter int          T_CKE_CYC    = 10,
    parameter int          T_XPR_CYC    = 6,
    parameter int          T_MRD_CYC    = 4,
    parameter int          T_MOD_CYC    = 12,
    parameter int          T_ZQINIT_CYC = 16,
    parameter logic [15:0] MR0_VAL      = 16'h0D70,
    parameter logic [15:0] MR1_VAL      = 16'h0001,
    parameter logic [15:0] MR2_VAL      = 16'h0000,
    parameter logic [15:0] MR3_VAL      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mr_req,
    input  logic [1:0]  mr_sel,
    input  logic [15:0] mr_data,
    output logic        mr_ack,
    output logic        busy,
    output logic        init_done,
    output logic        sel_passthrough,
    output logic        ddr3_reset_n,
    output logic        ddr3_cke,
    output logic        ddr3_cs_n,
    output logic        ddr3_ras_n,
    output logic        ddr3_cas_n,
    output logic        ddr3_we_n,
    output logic [2:0]  ddr3_ba,
    output logic [15:0] ddr3_adr
);

    localparam int T_MAX = max2(max2(max2(T_RESET_CYC, T_CKE_CYC), max2(T_XPR_CYC, T_MRD_CYC)),
                                max2(T_MOD_CYC, T_ZQINIT_CYC));
    localparam int CW = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] LD_RESET   = CW'(T_RESET_CYC - 1);
    localparam logic [CW-1:0] LD_CKE     = CW'(T_CKE_CYC - 1);
    localparam logic [CW-1:0] LD_XPR     = CW'(T_XPR_CYC - 1);
    localparam logic [CW-1:0] LD_MRD_GAP = CW'(gap_load(T_MRD_CYC));
    localparam logic [CW-1:0] LD_MOD_GAP = CW'(gap_load(T_MOD_CYC));
    localparam logic [CW-1:0] LD_ZQ      = CW'(gap_load(T_ZQINIT_CYC));
    localparam logic [CW-1:0] LD_USR_HLD = CW'(1);
    // The user gap also holds the ack cycle, hence N-1 rather than N-2.
    localparam logic [CW-1:0] LD_USR_GAP = CW'(T_MOD_CYC - 1);

    state_t        state_reg, state_next;
    logic [1:0]    mr_idx_reg, mr_idx_next;
    logic [1:0]    usr_sel_reg, usr_sel_next;
    logic [15:0]   usr_data_reg, usr_data_next;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_expired;

    logic          reset_n_reg, reset_n_next;
    logic          cke_reg, cke_next;
    logic [3:0]    cmd_reg, cmd_next;
    logic [2:0]    ba_reg, ba_next;
    logic [15:0]   adr_reg, adr_next;
    logic          ack_reg, ack_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          sel_reg, sel_next;

    function automatic logic [15:0] mr_payload(input logic [1:0] idx);
        case (idx)
            2'd0:    return MR0_VAL;
            2'd1:    return MR1_VAL;
            2'd2:    return MR2_VAL;
            default: return MR3_VAL;
        endcase
    endfunction

    init_delay_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Outputs are decoded from the current state and registered, so the bus
    // trails the state register by one cycle.
    always_comb begin
        state_next     = state_reg;
        mr_idx_next    = mr_idx_reg;
        usr_sel_next   = usr_sel_reg;
        usr_data_next  = usr_data_reg;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        reset_n_next   = 1'b1;
        cke_next       = 1'b1;
        cmd_next       = CMD_NOP;
        ba_next        = '0;
        adr_next       = '0;
        ack_next       = 1'b0;
        busy_next      = 1'b1;
        done_next      = 1'b0;
        sel_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                reset_n_next = 1'b0;
                cke_next     = 1'b0;
                cmd_next     = CMD_DESEL;
                busy_next    = 1'b0;
                if (start) begin
                    state_next  = RST_HOLD;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_RESET;
                    mr_idx_next = '0;
                end
            end
            RST_HOLD: begin
                reset_n_next = 1'b0;
                cke_next     = 1'b0;
                cmd_next     = CMD_DESEL;
                if (tmr_expired) begin
                    state_next = CKE_WAIT;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_CKE;
                end
            end
            CKE_WAIT: begin
                cke_next = 1'b0;
                cmd_next = CMD_DESEL;
                if (tmr_expired) begin
                    state_next = XPR_WAIT;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_XPR;
                end
            end
            XPR_WAIT: begin
                if (tmr_expired) state_next = MRS_ISSUE;
            end
            MRS_ISSUE: begin
                cmd_next    = CMD_MRS;
                ba_next     = {1'b0, MR_ORDER[mr_idx_reg]};
                adr_next    = mr_payload(MR_ORDER[mr_idx_reg]);
                mr_idx_next = mr_idx_reg + 2'd1;
                state_next  = MRS_GAP;
                tmr_load    = 1'b1;
                tmr_val     = (mr_idx_reg == 2'd3) ? LD_MOD_GAP : LD_MRD_GAP;
            end
            MRS_GAP: begin
                // Index wraps to zero once MR0 has gone out.
                if (tmr_expired) state_next = (mr_idx_reg == 2'd0) ? ZQ_ISSUE : MRS_ISSUE;
            end
            ZQ_ISSUE: begin
                cmd_next     = CMD_ZQCL;
                adr_next[10] = 1'b1;
                state_next   = ZQ_WAIT;
                tmr_load     = 1'b1;
                tmr_val      = LD_ZQ;
            end
            ZQ_WAIT: begin
                if (tmr_expired) state_next = DONE;
            end
            DONE: begin
                cmd_next  = CMD_DESEL;
                busy_next = 1'b0;
                done_next = 1'b1;
                sel_next  = 1'b1;
                if (start) begin
                    state_next  = RST_HOLD;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_RESET;
                    mr_idx_next = '0;
                end else if (mr_req) begin
                    state_next    = USR_ISSUE;
                    tmr_load      = 1'b1;
                    tmr_val       = LD_USR_HLD;
                    usr_sel_next  = mr_sel;
                    usr_data_next = mr_data;
                end
            end
            USR_ISSUE: begin
                // First cycle only releases the bus from the translator.
                if (tmr_expired) begin
                    cmd_next   = CMD_MRS;
                    ba_next    = {1'b0, usr_sel_reg};
                    adr_next   = usr_data_reg;
                    state_next = USR_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_USR_GAP;
                end
            end
            USR_GAP: begin
                if (tmr_expired) begin
                    ack_next   = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    sel_next   = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mr_idx_reg   <= '0;
            usr_sel_reg  <= '0;
            usr_data_reg <= '0;
            reset_n_reg  <= 1'b0;
            cke_reg      <= 1'b0;
            cmd_reg      <= CMD_DESEL;
            ba_reg       <= '0;
            adr_reg      <= '0;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sel_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mr_idx_reg   <= mr_idx_next;
            usr_sel_reg  <= usr_sel_next;
            usr_data_reg <= usr_data_next;
            reset_n_reg  <= reset_n_next;
            cke_reg      <= cke_next;
            cmd_reg      <= cmd_next;
            ba_reg       <= ba_next;
            adr_reg      <= adr_next;
            ack_reg      <= ack_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            sel_reg      <= sel_next;
        end
    end

    assign ddr3_reset_n    = reset_n_reg;
    assign ddr3_cke        = cke_reg;
    assign ddr3_cs_n       = cmd_reg[3];
    assign ddr3_ras_n      = cmd_reg[2];
    assign ddr3_cas_n      = cmd_reg[1];
    assign ddr3_we_n       = cmd_reg[0];
    assign ddr3_ba         = ba_reg;
    assign ddr3_adr        = adr_reg;
    assign mr_ack          = ack_reg;
    assign busy            = busy_reg;
    assign init_done       = done_reg;
    assign sel_passthrough = sel_reg;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Scoreboard bench for ddr3_init_sequencer: expected bus commands and acks are
// queued with their absolute edge number and matched against a negedge monitor.
module tb_ddr3_init_sequencer;

    localparam logic [3:0]  NOP  = 4'b0111;
    localparam logic [3:0]  MRS  = 4'b0000;
    localparam logic [3:0]  ZQCL = 4'b0110;
    localparam logic [3:0]  ACK  = 4'b1000;
    localparam logic [15:0] MR0  = 16'h0D70;
    localparam logic [15:0] MR1  = 16'h0001;
    localparam logic [15:0] MR2  = 16'h0000;
    localparam logic [15:0] MR3  = 16'h0000;

    typedef struct packed {
        logic [31:0] t;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [15:0] adr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mr_req = 1'b0;
    logic [1:0]  mr_sel = 2'd0;
    logic [15:0] mr_data = 16'h0000;
    logic        mr_ack, busy, init_done, sel_passthrough;
    logic        ddr3_reset_n, ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n;
    logic [2:0]  ddr3_ba;
    logic [15:0] ddr3_adr;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    wire [3:0] cmd_now = {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n};

    ddr3_init_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mr_req          (mr_req),
        .mr_sel          (mr_sel),
        .mr_data         (mr_data),
        .mr_ack          (mr_ack),
        .busy            (busy),
        .init_done       (init_done),
        .sel_passthrough (sel_passthrough),
        .ddr3_reset_n    (ddr3_reset_n),
        .ddr3_cke        (ddr3_cke),
        .ddr3_cs_n       (ddr3_cs_n),
        .ddr3_ras_n      (ddr3_ras_n),
        .ddr3_cas_n      (ddr3_cas_n),
        .ddr3_we_n       (ddr3_we_n),
        .ddr3_ba         (ddr3_ba),
        .ddr3_adr        (ddr3_adr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int t, input logic [3:0] c, input logic [2:0] b,
                                  input logic [15:0] a);
        ev_t e;
        e.t   = t;
        e.cmd = c;
        e.ba  = b;
        e.adr = a;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && ddr3_cs_n === 1'b0 && cmd_now !== NOP)
            obs_q.push_back(mk_ev(cyc, cmd_now, ddr3_ba, ddr3_adr));
        if (mr_ack === 1'b1)
            obs_q.push_back(mk_ev(cyc, ACK, 3'd0, 16'h0000));
    end

    task automatic push_init(input int s);
        exp_q.push_back(mk_ev(s + 25, MRS, 3'd2, MR2));
        exp_q.push_back(mk_ev(s + 29, MRS, 3'd3, MR3));
        exp_q.push_back(mk_ev(s + 33, MRS, 3'd1, MR1));
        exp_q.push_back(mk_ev(s + 37, MRS, 3'd0, MR0));
        exp_q.push_back(mk_ev(s + 49, ZQCL, 3'd0, 16'h0400));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ddr3_reset_n, ddr3_cke, cmd_now} !== 6'b001111) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=001111", {ddr3_reset_n, ddr3_cke, cmd_now});
        end
        checks++;
        if ({ddr3_ba, ddr3_adr} !== 19'd0) begin
            errors++;
            $display("FAIL reset_addr got ba=%0d adr=%h exp 0/0000", ddr3_ba, ddr3_adr);
        end
        checks++;
        if ({mr_ack, busy, init_done, sel_passthrough} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status got=%b exp=0000", {mr_ack, busy, init_done, sel_passthrough});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ddr3_reset_n, ddr3_cke, cmd_now, busy} !== 7'b0011110) begin
            errors++;
            $display("FAIL idle_hold got=%b exp=0011110", {ddr3_reset_n, ddr3_cke, cmd_now, busy});
        end
    endtask

    task automatic test_power_up();
        int  t0, k;
        logic [4:0] got_st, exp_st;
        logic is_cmd;
        ev_t e, o;
        obs_q.delete();
        exp_q.delete();
        t0 = cyc + 1;
        push_init(t0);
        start = 1'b1;
        for (int n = 0; n <= 66; n++) begin
            @(negedge clk);
            start = 1'b0;
            k = cyc - t0;
            exp_st = {k >= 9, k >= 19, (k >= 1 && k < 65), k >= 65, k >= 65};
            got_st = {ddr3_reset_n, ddr3_cke, busy, init_done, sel_passthrough};
            checks++;
            if (got_st !== exp_st) begin
                errors++;
                $display("FAIL pu_status k=%0d got=%b exp=%b", k, got_st, exp_st);
            end
            is_cmd = (k == 25 || k == 29 || k == 33 || k == 37 || k == 49);
            if (k < 19) begin
                checks++;
                if (ddr3_cs_n !== 1'b1) begin
                    errors++;
                    $display("FAIL pu_cs_early k=%0d got cs_n=%b exp=1", k, ddr3_cs_n);
                end
            end else if (k < 65 && !is_cmd) begin
                checks++;
                if ({cmd_now, ddr3_ba, ddr3_adr} !== {NOP, 3'd0, 16'd0}) begin
                    errors++;
                    $display("FAIL pu_nop k=%0d got cmd=%b ba=%0d adr=%h exp NOP", k, cmd_now, ddr3_ba, ddr3_adr);
                end
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pu_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("txn pu t=%0d cmd=%b ba=%0d adr=%h", o.t - t0, o.cmd, o.ba, o.adr);
            if (o !== e) begin
                errors++;
                $display("FAIL pu_event got t=%0d cmd=%b ba=%0d adr=%h exp t=%0d cmd=%b ba=%0d adr=%h",
                         o.t - t0, o.cmd, o.ba, o.adr, e.t - t0, e.cmd, e.ba, e.adr);
            end
        end
    endtask

    task automatic test_user_mrs();
        int  a;
        bit  got_ack;
        ev_t e, o;
        obs_q.delete();
        exp_q.delete();
        a = cyc + 1;
        exp_q.push_back(mk_ev(a + 2, MRS, 3'd1, 16'h0044));
        exp_q.push_back(mk_ev(a + 14, ACK, 3'd0, 16'h0000));
        mr_req  = 1'b1;
        mr_sel  = 2'd1;
        mr_data = 16'h0044;
        got_ack = 1'b0;
        for (int n = 0; n < 40 && !got_ack; n++) begin
            @(negedge clk);
            if (cyc == a) begin
                mr_sel  = 2'd3;
                mr_data = 16'hFFFF;
            end
            if (cyc == a + 1) begin
                checks++;
                if (sel_passthrough !== 1'b0) begin
                    errors++;
                    $display("FAIL usr_sel_drop got=%b exp=0", sel_passthrough);
                end
            end
            if (mr_ack === 1'b1) begin
                got_ack = 1'b1;
                mr_req  = 1'b0;
                checks++;
                if (sel_passthrough !== 1'b1) begin
                    errors++;
                    $display("FAIL usr_sel_back got=%b exp=1", sel_passthrough);
                end
            end
        end
        checks++;
        if (!got_ack) begin
            errors++;
            $display("FAIL usr_ack_timeout got=no ack exp=ack within 40 cycles");
        end
        @(negedge clk);
        checks++;
        if ({mr_ack, sel_passthrough} !== 2'b01) begin
            errors++;
            $display("FAIL usr_ack_pulse got ack,sel=%b exp=01", {mr_ack, sel_passthrough});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL usr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("txn usr t=%0d cmd=%b ba=%0d adr=%h", o.t - a, o.cmd, o.ba, o.adr);
            if (o !== e) begin
                errors++;
                $display("FAIL usr_event got t=%0d cmd=%b ba=%0d adr=%h exp t=%0d cmd=%b ba=%0d adr=%h",
                         o.t - a, o.cmd, o.ba, o.adr, e.t - a, e.cmd, e.ba, e.adr);
            end
        end
    endtask

    // Restart from DONE, user request raised mid-init, and a start pulse while busy.
    task automatic test_req_during_init();
        int  s, k;
        ev_t e, o;
        obs_q.delete();
        exp_q.delete();
        s = cyc + 1;
        push_init(s);
        exp_q.push_back(mk_ev(s + 67, MRS, 3'd2, 16'hBEEF));
        exp_q.push_back(mk_ev(s + 79, ACK, 3'd0, 16'h0000));
        start = 1'b1;
        for (int n = 0; n <= 85; n++) begin
            @(negedge clk);
            start = 1'b0;
            k = cyc - s;
            if (k == 1) begin
                checks++;
                if ({init_done, sel_passthrough, busy} !== 3'b001) begin
                    errors++;
                    $display("FAIL rei_drop got done,sel,busy=%b exp=001", {init_done, sel_passthrough, busy});
                end
            end
            if (k == 29) begin
                mr_req  = 1'b1;
                mr_sel  = 2'd2;
                mr_data = 16'hBEEF;
            end
            if (k == 39) start = 1'b1;
            if (k == 65) begin
                checks++;
                if ({init_done, sel_passthrough} !== 2'b11) begin
                    errors++;
                    $display("FAIL rei_done got=%b exp=11", {init_done, sel_passthrough});
                end
            end
            if (mr_ack === 1'b1) mr_req = 1'b0;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rei_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("txn rei t=%0d cmd=%b ba=%0d adr=%h", o.t - s, o.cmd, o.ba, o.adr);
            if (o !== e) begin
                errors++;
                $display("FAIL rei_event got t=%0d cmd=%b ba=%0d adr=%h exp t=%0d cmd=%b ba=%0d adr=%h",
                         o.t - s, o.cmd, o.ba, o.adr, e.t - s, e.cmd, e.ba, e.adr);
            end
        end
    endtask

    task automatic test_start_and_req();
        int  s;
        ev_t e, o;
        obs_q.delete();
        exp_q.delete();
        s = cyc + 1;
        push_init(s);
        exp_q.push_back(mk_ev(s + 67, MRS, 3'd3, 16'h0A5A));
        exp_q.push_back(mk_ev(s + 79, ACK, 3'd0, 16'h0000));
        start   = 1'b1;
        mr_req  = 1'b1;
        mr_sel  = 2'd3;
        mr_data = 16'h0A5A;
        for (int n = 0; n <= 85; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == s + 1) begin
                checks++;
                if ({busy, sel_passthrough, ddr3_reset_n} !== 3'b100) begin
                    errors++;
                    $display("FAIL both_start_wins got busy,sel,reset_n=%b exp=100",
                             {busy, sel_passthrough, ddr3_reset_n});
                end
            end
            if (mr_ack === 1'b1) mr_req = 1'b0;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL both_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("txn both t=%0d cmd=%b ba=%0d adr=%h", o.t - s, o.cmd, o.ba, o.adr);
            if (o !== e) begin
                errors++;
                $display("FAIL both_event got t=%0d cmd=%b ba=%0d adr=%h exp t=%0d cmd=%b ba=%0d adr=%h",
                         o.t - s, o.cmd, o.ba, o.adr, e.t - s, e.cmd, e.ba, e.adr);
            end
        end
    endtask

    task automatic test_rst_mid();
        int  s;
        ev_t e, o;
        obs_q.delete();
        exp_q.delete();
        s = cyc + 1;
        exp_q.push_back(mk_ev(s + 25, MRS, 3'd2, MR2));
        exp_q.push_back(mk_ev(s + 29, MRS, 3'd3, MR3));
        exp_q.push_back(mk_ev(s + 33, MRS, 3'd1, MR1));
        start = 1'b1;
        for (int n = 0; n < 40 && cyc < s + 34; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == s + 29) begin
                mr_req  = 1'b1;
                mr_sel  = 2'd1;
                mr_data = 16'h1111;
            end
        end
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mr_req = 1'b0;
        #1;
        checks++;
        if ({ddr3_reset_n, ddr3_cke, cmd_now, ddr3_ba, ddr3_adr} !== {6'b001111, 19'd0}) begin
            errors++;
            $display("FAIL rst_bus got reset_n,cke,cmd=%b ba=%0d adr=%h exp 001111/0/0000",
                     {ddr3_reset_n, ddr3_cke, cmd_now}, ddr3_ba, ddr3_adr);
        end
        checks++;
        if ({mr_ack, busy, init_done, sel_passthrough} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_status got=%b exp=0000", {mr_ack, busy, init_done, sel_passthrough});
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("txn rst t=%0d cmd=%b ba=%0d adr=%h", o.t - s, o.cmd, o.ba, o.adr);
            if (o !== e) begin
                errors++;
                $display("FAIL rst_event got t=%0d cmd=%b ba=%0d adr=%h exp t=%0d cmd=%b ba=%0d adr=%h",
                         o.t - s, o.cmd, o.ba, o.adr, e.t - s, e.cmd, e.ba, e.adr);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_user_mrs();
        test_req_during_init();
        test_start_and_req();
        test_rst_mid();
        test_power_up();
        test_user_mrs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ddr3_init_sequencer.md
Name: ddr3_init_sequencer

Overview:
- Owns the DDR3 command/address bus at power-up and runs the JEDEC DDR3 initialisation sequence: RESET# hold, CKE hold, tXPR, MRS MR2/MR3/MR1/MR0, then ZQCL.
- Once init completes, raises sel_passthrough so the board-level mux hands the DDR3 bus to the DDR4→DDR3 translator path.
- After init, also serves single runtime MRS requests with tMOD spacing; the translator bus is held off for the duration of each request.

Parameters:
- T_RESET_CYC, 8, cycles ddr3_reset_n is held low after start.
- T_CKE_CYC, 10, cycles CKE stays low after reset_n rises.
- T_XPR_CYC, 6, NOP cycles from CKE high to the first MRS.
- T_MRD_CYC, 4, command-to-command spacing between MRS commands (≥2).
- T_MOD_CYC, 12, cycles from an MRS to the next non-MRS command, or to a user-request ack.
- T_ZQINIT_CYC, 16, cycles from ZQCL to init_done.
- MR0_VAL / MR1_VAL / MR2_VAL / MR3_VAL, 16'h0D70 / 16'h0001 / 16'h0000 / 16'h0000, DDR3 A[15:0] payloads.

Ports:
- clk  in  1  controller clock (same as ddr3_ck_t domain)
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that (re)starts full initialisation
- mr_req  in  1  runtime MRS request; held until mr_ack
- mr_sel  in  2  target MR index (BA[1:0])
- mr_data  in  16  MR payload for A[15:0]
- mr_ack  out  1  one-cycle pulse when the request completes, tMOD elapsed
- busy  out  1  high in every state except IDLE and DONE
- init_done  out  1  high only in DONE
- sel_passthrough  out  1  high only in DONE with no user MRS active
- ddr3_reset_n, ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n  out  1 each  DDR3 control
- ddr3_ba  out  3  bank address
- ddr3_adr  out  16  address

Behaviour:
- All outputs registered.
- Reset values:
  - ddr3_reset_n=0, ddr3_cke=0
  - ddr3_cs_n=1, ras_n=cas_n=we_n=1
  - ddr3_ba=0, ddr3_adr=0
  - mr_ack=0, busy=0, init_done=0, sel_passthrough=0
  - State IDLE.
- Command encodings, each driven for exactly one cycle:
  - NOP: cs_n=0, ras/cas/we=1, ba=0, adr=0.
  - MRS: cs_n=0, ras/cas/we=0, ba={0,mr#}, adr=payload.
  - ZQCL: cs_n=0, ras=cas=1, we=0, adr[10]=1, all other adr bits 0, ba=0.
- States: IDLE → RST_HOLD → CKE_WAIT → XPR_WAIT → MRS_ISSUE ⇄ MRS_GAP → ZQ_ISSUE → ZQ_WAIT → DONE ⇄ USR_ISSUE → USR_GAP.
- IDLE: reset_n=0, cke=0, cs_n=1. start → RST_HOLD.
- RST_HOLD: reset_n=0 for T_RESET_CYC cycles, then reset_n=1 → CKE_WAIT.
- CKE_WAIT: cke=0, cs_n=1 for T_CKE_CYC cycles, then cke=1 → XPR_WAIT.
- XPR_WAIT: NOP for T_XPR_CYC cycles.
- MRS order MR2, MR3, MR1, MR0, tracked by a 2-bit index.
  - Successive MRS commands are T_MRD_CYC cycles apart, with NOPs in between.
  - MR0 is followed by T_MOD_CYC cycles before ZQCL.
- ZQ_WAIT: NOP for T_ZQINIT_CYC cycles → DONE. init_done=1 and sel_passthrough=1 in the same cycle.
- Absolute timing with start sampled at edge 0:
  - reset_n rises at edge 1+T_RESET_CYC.
  - cke rises at edge 1+T_RESET_CYC+T_CKE_CYC.
  - First MRS at edge 1+T_RESET_CYC+T_CKE_CYC+T_XPR_CYC.
- DONE with mr_req=1:
  - sel_passthrough drops in the next cycle.
  - The cycle after that issues MRS with ba={0,mr_sel} and adr=mr_data; both are captured when the request is accepted.
  - NOP for T_MOD_CYC cycles, then mr_ack pulses for 1 cycle and sel_passthrough returns to 1 in the same cycle.
- mr_req while not in DONE: stalled, mr_ack stays 0.
- start while busy: ignored.
- start in DONE: full re-init from RST_HOLD, and init_done drops.
- start and mr_req together in DONE: start wins, and mr_req stays pending until the next DONE.
- rst asserted mid-sequence: immediate return to reset values. Any pending user request is dropped with no ack.
- Counter is a single down-counter, loaded with N-1 on state entry. Width is clog2 of the largest T_* parameter. A T_* value of 1 gives a single-cycle state.

Decomposition:
- Package ddr3_init_pkg:
  - state enum
  - command encoding constants {cs_n,ras_n,cas_n,we_n} for NOP, MRS and ZQCL
  - MR issue-order constant array (2,3,1,0)
- Sub-module init_delay_timer: load / count-value / expired down-counter, reused by every wait state.

Test Plan:
- Power-up with default params, start at edge 0:
  - reset_n rises at edge 9, cke at edge 19.
  - MRS MR2/MR3/MR1/MR0 at edges 25/29/33/37 with ba 2/3/1/0 and adr matching MRn_VAL.
  - ZQCL at edge 49 with adr=16'h0400.
  - init_done and sel_passthrough rise at edge 65.
- Every non-command cycle between edges 19 and 65 is an exact NOP encoding. No cycle has cs_n=0 before edge 19.
- After DONE, mr_req with mr_sel=1, mr_data=16'h0044:
  - sel_passthrough=0 the next cycle.
  - MRS with ba=1, adr=16'h0044 one cycle later.
  - mr_ack pulses 12 cycles after the MRS.
  - sel_passthrough back to 1 with the ack.
- mr_req raised at edge 30, during init: no ack until init_done. Its MRS issues at edge 67.
- rst pulsed at edge 35, mid-MRS gap: all outputs return to reset values within that cycle. A later start repeats the full edge-by-edge timeline.
- start at edge 40, while busy: timeline unchanged.
- start together with mr_req in DONE: re-init runs first, and the pending request is served after the new DONE.
